// File: rtl/trace_buffer_drain.sv
`default_nettype none
// ============================================================================
//  Module   : trace_buffer_drain
//  Purpose  : Captures packed N-lane vectors into a TB_SIZE-deep circular
//             trace buffer while tracing is high. The buffer either wraps
//             (the oldest entry is lost) or stops when full. While tracing is
//             low, a drain request replays the contents oldest-first through
//             a registered valid/ready readout port.
//  Ports    : clk, rst (async, active-high)
//             tracing, valid_in, vector_in     - capture side
//             configId, configData             - byte-wide config bus
//             drain_start, ready_in            - drain request / consumer
//             vector_out, valid_out            - drained entry
//             drain_done                       - pulse after last accept
//             overflow                         - sticky overwrite/drop flag
//             occupancy                        - entries held (0..TB_SIZE)
//             timestamp_out                    - only with TB_TIMESTAMP_EN
//  Options  : `define TB_TIMESTAMP_EN adds a 32-bit free-running cycle counter,
//             per-entry timestamp storage and the timestamp_out port.
//  Revision : 1.0  initial release
// ============================================================================
module trace_buffer_drain #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int TB_SIZE            = 16,
    parameter int PERSONAL_CONFIG_ID = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tracing,
    input  logic                          valid_in,
    input  logic [DATA_WIDTH*N-1:0]       vector_in,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic                          drain_start,
    input  logic                          ready_in,
    output logic [DATA_WIDTH*N-1:0]       vector_out,
    output logic                          valid_out,
    output logic                          drain_done,
    output logic                          overflow,
    output logic [$clog2(TB_SIZE):0]      occupancy
`ifdef TB_TIMESTAMP_EN
    ,
    output logic [31:0]                   timestamp_out
`endif
);

    localparam int AW = $clog2(TB_SIZE);
    localparam int OW = AW + 1;
    localparam int VW = DATA_WIDTH * N;

    localparam logic [1:0]    C_IDLE    = 2'd0;
    localparam logic [1:0]    C_CAPTURE = 2'd1;
    localparam logic [1:0]    C_DRAIN   = 2'd2;

    localparam logic [OW-1:0] C_FULL    = OW'(TB_SIZE);
    localparam logic [OW-1:0] C_ONE     = OW'(1);
    localparam logic [OW-1:0] C_ZERO    = '0;
    localparam logic [7:0]    C_CFG_ID  = 8'(PERSONAL_CONFIG_ID);

    logic [1:0]    state_q,      state_d;
    logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [AW-1:0] fetch_ptr_q,  fetch_ptr_d;
    logic [OW-1:0] occ_q,        occ_d;
    logic [OW-1:0] fetch_left_q, fetch_left_d;
    logic [7:0]    byte_cnt_q,   byte_cnt_d;
    logic          mode_q,       mode_d;      // 0 = wrap, 1 = stop
    logic          ovf_q,        ovf_d;
    logic [VW-1:0] vec_q,        vec_d;
    logic          valid_q,      valid_d;
    logic          done_q,       done_d;

    logic [VW-1:0] mem_q [TB_SIZE];

    logic w_full;
    logic w_xfer;
    logic w_mem_we;
    logic w_cfg_hit;

`ifdef TB_TIMESTAMP_EN
    logic [31:0] cycle_q;
    logic [31:0] ts_q, ts_d;
    logic [31:0] ts_mem_q [TB_SIZE];
`endif

    assign w_full    = (occ_q == C_FULL);
    assign w_xfer    = valid_q && ready_in;
    // In stop mode a full buffer drops the incoming vector entirely.
    assign w_mem_we  = (state_q == C_CAPTURE) && valid_in && (!w_full || !mode_q);
    assign w_cfg_hit = !tracing && (state_q == C_IDLE) && (configId == C_CFG_ID);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fetch_ptr_d  = fetch_ptr_q;
        occ_d        = occ_q;
        fetch_left_d = fetch_left_q;
        byte_cnt_d   = byte_cnt_q;
        mode_d       = mode_q;
        ovf_d        = ovf_q;
        vec_d        = vec_q;
        valid_d      = valid_q;
        done_d       = 1'b0;
`ifdef TB_TIMESTAMP_EN
        ts_d         = ts_q;
`endif

        case (state_q)
            C_IDLE: begin
                if (tracing) begin
                    state_d = C_CAPTURE;
                end else if (drain_start) begin
                    if (occ_q != C_ZERO) begin
                        // Fetch walks its own pointer so rd_ptr/occupancy only
                        // move on accepted transfers.
                        state_d      = C_DRAIN;
                        fetch_ptr_d  = rd_ptr_q;
                        fetch_left_d = occ_q;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            C_CAPTURE: begin
                if (!tracing) begin
                    state_d = C_IDLE;
                end
                if (valid_in) begin
                    if (!w_full) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        occ_d    = occ_q + 1'b1;
                    end else if (!mode_q) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        ovf_d    = 1'b1;
                    end else begin
                        ovf_d    = 1'b1;
                    end
                end
            end

            C_DRAIN: begin
                // Output register is refilled whenever it is empty or being
                // consumed this cycle; otherwise it holds its value.
                if (!valid_q || w_xfer) begin
                    if (fetch_left_q != C_ZERO) begin
                        vec_d        = mem_q[fetch_ptr_q];
`ifdef TB_TIMESTAMP_EN
                        ts_d         = ts_mem_q[fetch_ptr_q];
`endif
                        valid_d      = 1'b1;
                        fetch_ptr_d  = fetch_ptr_q + 1'b1;
                        fetch_left_d = fetch_left_q - 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                if (w_xfer) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    occ_d    = occ_q - 1'b1;
                    if (occ_q == C_ONE) begin
                        state_d = C_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = C_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Config bus: byte 0 of a burst addressed to this block carries
        // mode and clear; later bytes are counted but ignored.
        if (configId != C_CFG_ID) begin
            byte_cnt_d = 8'd0;
        end else if (w_cfg_hit) begin
            if (byte_cnt_q != 8'hFF) begin
                byte_cnt_d = byte_cnt_q + 8'd1;
            end
            if (byte_cnt_q == 8'd0) begin
                mode_d = configData[0];
                if (configData[1]) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    occ_d    = '0;
                    ovf_d    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= C_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            occ_q        <= '0;
            fetch_left_q <= '0;
            byte_cnt_q   <= 8'd0;
            mode_q       <= 1'b0;
            ovf_q        <= 1'b0;
            vec_q        <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            occ_q        <= occ_d;
            fetch_left_q <= fetch_left_d;
            byte_cnt_q   <= byte_cnt_d;
            mode_q       <= mode_d;
            ovf_q        <= ovf_d;
            vec_q        <= vec_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[wr_ptr_q] <= vector_in;
        end
    end

`ifdef TB_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= 32'd0;
            ts_q    <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            ts_q    <= ts_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            ts_mem_q[wr_ptr_q] <= cycle_q;
        end
    end

    assign timestamp_out = valid_q ? ts_q : 32'd0;
`endif

    assign vector_out = vec_q;
    assign valid_out  = valid_q;
    assign drain_done = done_q;
    assign overflow   = ovf_q;
    assign occupancy  = occ_q;

endmodule
`default_nettype wire
